// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU micro-sequencer: opcodes, FSM states,
// word widths and the rule for which opcodes write back to W and the flags.
package alu_pkg;

  localparam int INSTR_W = 12;
  localparam int DATA_W  = 8;

  typedef enum logic [3:0] {
    OP_PASSB = 4'd0,
    OP_PASSA = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_INC   = 4'd5,
    OP_DEC   = 4'd6,
    OP_XOR   = 4'd7,
    OP_NOP   = 4'd8,
    OP_CLR   = 4'd9,
    OP_IOR   = 4'd10,
    OP_SWAP  = 4'd11,
    OP_HALT  = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_DONE
  } state_t;

  // Opcode presented to the ALU whenever no instruction is executing.
  localparam logic [3:0] ALU_HOLD = 4'(OP_NOP);

  // Opcodes 0-7 and 9-11 produce a result that lands in W and the flags.
  function automatic logic writes_w(input logic [3:0] op);
    return (op <= 4'd7) || ((op >= 4'd9) && (op <= 4'd11));
  endfunction

endpackage

// File: rtl/alu_seq_regs.sv
// Working register W plus carry/zero flags, loaded from the 9-bit ALU result.
module alu_seq_regs
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W:0]   ans,
  output logic [DATA_W-1:0] w,
  output logic              carry,
  output logic              zero
);

  // Capture the ALU result and derive the flags on a write-enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      w     <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (we) begin
      w     <= ans[DATA_W-1:0];
      carry <= ans[DATA_W];
      zero  <= (ans[DATA_W-1:0] == '0);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer: fetches 12-bit instructions from a synchronous program
// memory, drives the combinational ALU and writes results back into W/flags.
// Each non-halt instruction takes FETCH, LOAD, EXEC (3 cycles).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int         PC_W    = 4,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [3:0]         alu_inst,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W:0]    alu_ans,
  output logic [DATA_W-1:0]  w_out,
  output logic               carry,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               wr_en;

  // Result write-back happens only on the edge that ends EXEC.
  assign wr_en     = (state == ST_EXEC) && writes_w(ir[11:8]);
  assign prog_addr = pc;
  assign alu_b     = ir[7:0];
  assign alu_a     = w_out;

  alu_seq_regs u_regs (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .ans   (alu_ans),
    .w     (w_out),
    .carry (carry),
    .zero  (zero)
  );

  // Control FSM; alu_inst, busy and done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      alu_inst <= ALU_HOLD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      alu_inst <= ALU_HOLD;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc    <= '0;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          ir <= prog_data;
          if (prog_data[11:8] == HALT_OP) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            alu_inst <= prog_data[11:8];
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc    <= pc + PC_W'(1);
          state <= ST_FETCH;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and synchronous ROM, a table of
// short programs with per-instruction W/flag expectations, plus hand-written
// sequences for PC wrap, mid-run reset, ignored start and held start.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;

  logic [3:0]  addr1;
  logic [11:0] data1;
  logic [3:0]  inst1;
  logic [7:0]  a1, b1, w1;
  logic [8:0]  ans1;
  logic        c1, z1, busy1, done1;

  logic [1:0]  addr2;
  logic [11:0] data2;
  logic [3:0]  inst2;
  logic [7:0]  a2, b2, w2;
  logic [8:0]  ans2;
  logic        c2, z2, busy2, done2;

  logic [11:0] mem1 [16];
  logic [11:0] mem2 [4];

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(4), .HALT_OP(4'hF)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_addr(addr1), .prog_data(data1),
    .alu_inst(inst1), .alu_a(a1), .alu_b(b1), .alu_ans(ans1),
    .w_out(w1), .carry(c1), .zero(z1), .busy(busy1), .done(done1)
  );

  alu_sequencer #(.PC_W(2), .HALT_OP(4'hF)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .prog_addr(addr2), .prog_data(data2),
    .alu_inst(inst2), .alu_a(a2), .alu_b(b2), .alu_ans(ans2),
    .w_out(w2), .carry(c2), .zero(z2), .busy(busy2), .done(done2)
  );

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      4'd0:    return {1'b0, b};
      4'd1:    return {1'b0, a};
      4'd2:    return {1'b0, a} + {1'b0, b};
      4'd3:    return {1'b0, a} - {1'b0, b};
      4'd4:    return {1'b0, a & b};
      4'd5:    return {1'b0, a} + 9'd1;
      4'd6:    return {1'b0, a} - 9'd1;
      4'd7:    return {1'b0, a ^ b};
      4'd9:    return 9'd0;
      4'd10:   return {1'b0, a | b};
      4'd11:   return {1'b0, b[3:0], b[7:4]};
      default: return 9'd0;
    endcase
  endfunction

  // Combinational ALU models for both sequencer instances.
  always_comb begin
    ans1 = alu_f(inst1, a1, b1);
    ans2 = alu_f(inst2, a2, b2);
  end

  // Synchronous program memories: data valid one cycle after the address.
  always @(posedge clk) begin
    data1 <= mem1[addr1];
    data2 <= mem2[addr2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] prog [5];
    logic [7:0]  ew [4];
    logic [3:0]  ec;
    logic [3:0]  ez;
    int          n;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [11:0] p0, p1, p2, p3, p4,
                              input logic [7:0] w0, w1v, w2v, w3,
                              input logic [3:0] c, z, input int n, input int lat);
    vec_t v;
    v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3; v.prog[4] = p4;
    v.ew[0] = w0; v.ew[1] = w1v; v.ew[2] = w2v; v.ew[3] = w3;
    v.ec = c; v.ez = z; v.n = n; v.lat = lat;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  vec_t vt [10];

  initial begin
    bit seen;
    // flags given as masks: bit k = expected flag after instruction k
    vt[0] = mk(12'h035, 12'h2CB, 12'hF00, 12'hF00, 12'hF00, 8'h35, 8'h00, 8'h00, 8'h00, 4'b0010, 4'b0010, 2, 9);
    vt[1] = mk(12'h010, 12'h320, 12'hF00, 12'hF00, 12'hF00, 8'h10, 8'hF0, 8'h00, 8'h00, 4'b0010, 4'b0000, 2, 9);
    vt[2] = mk(12'h020, 12'h310, 12'hF00, 12'hF00, 12'hF00, 8'h20, 8'h10, 8'h00, 8'h00, 4'b0000, 4'b0000, 2, 9);
    vt[3] = mk(12'h0A5, 12'h8FF, 12'hC12, 12'hF00, 12'hF00, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'b0000, 4'b0000, 3, 12);
    vt[4] = mk(12'hB3C, 12'h000, 12'h600, 12'hF00, 12'hF00, 8'hC3, 8'h00, 8'hFF, 8'h00, 4'b0100, 4'b0010, 3, 12);
    vt[5] = mk(12'h0FF, 12'h500, 12'hF00, 12'hF00, 12'hF00, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0010, 4'b0010, 2, 9);
    vt[6] = mk(12'h0F0, 12'h40F, 12'hA3C, 12'h7FF, 12'hF00, 8'hF0, 8'h00, 8'h3C, 8'hC3, 4'b0000, 4'b0010, 4, 15);
    vt[7] = mk(12'h055, 12'h900, 12'hF00, 12'hF00, 12'hF00, 8'h55, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0010, 2, 9);
    vt[8] = mk(12'h0FF, 12'h501, 12'hE77, 12'hD00, 12'hF00, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b1110, 4'b1110, 4, 15);
    vt[9] = mk(12'hF00, 12'h0AA, 12'hF00, 12'hF00, 12'hF00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 3);

    mem2[0] = 12'h501; mem2[1] = 12'h500; mem2[2] = 12'h500; mem2[3] = 12'h500;

    // ---- table-driven programs ----
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) mem1[j] = 12'hF00;
      for (int j = 0; j < 5; j++) mem1[j] = vt[i].prog[j];
      do_reset();
      chk($sformatf("v%0d_rst_w", i), 32'(w1), 32'h0);
      chk($sformatf("v%0d_rst_c", i), 32'(c1), 32'h0);
      chk($sformatf("v%0d_rst_z", i), 32'(z1), 32'h0);
      chk($sformatf("v%0d_rst_busy", i), 32'(busy1), 32'h0);
      chk($sformatf("v%0d_rst_done", i), 32'(done1), 32'h0);
      chk($sformatf("v%0d_rst_inst", i), 32'(inst1), 32'h8);
      chk($sformatf("v%0d_rst_addr", i), 32'(addr1), 32'h0);
      do_start();
      seen = 1'b0;
      for (int e = 0; e < 60; e++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          if (k < vt[i].n && e == 3 * k + 3) begin
            chk($sformatf("v%0d_w%0d", i, k), 32'(w1), 32'(vt[i].ew[k]));
            chk($sformatf("v%0d_c%0d", i, k), 32'(c1), 32'(vt[i].ec[k]));
            chk($sformatf("v%0d_z%0d", i, k), 32'(z1), 32'(vt[i].ez[k]));
          end
        end
        if (!done1) chk($sformatf("v%0d_busy_e%0d", i, e), 32'(busy1), 32'h1);
        if (done1) begin
          chk($sformatf("v%0d_done_lat", i), 32'(e + 1), 32'(vt[i].lat));
          seen = 1'b1;
          break;
        end
      end
      chk($sformatf("v%0d_done_seen", i), 32'(seen), 32'h1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done1), 32'h0);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy1), 32'h0);
    end

    // ---- PC wrap, PC_W=2, no HALT ----
    do_reset();
    do_start();
    for (int e = 0; e <= 15; e++) begin
      @(negedge clk);
      if (e % 3 == 0 && e <= 12)
        chk($sformatf("wrap_addr_e%0d", e), 32'(addr2), 32'((e / 3) % 4));
      if (e % 3 == 0 && e >= 3)
        chk($sformatf("wrap_w_e%0d", e), 32'(w2), 32'(e / 3));
      chk($sformatf("wrap_busy_e%0d", e), 32'(busy2), 32'h1);
      chk($sformatf("wrap_done_e%0d", e), 32'(done2), 32'h0);
    end

    // ---- ignored start while busy, then reset mid-EXEC of 0x2CB ----
    for (int j = 0; j < 16; j++) mem1[j] = 12'hF00;
    mem1[0] = 12'h035; mem1[1] = 12'h2CB;
    do_reset();
    do_start();
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      if (e == 3) begin
        chk("mid_w_after_ld", 32'(w1), 32'h35);
        start = 1'b1;
      end
      if (e == 4) begin
        start = 1'b0;
        chk("mid_start_ignored_addr", 32'(addr1), 32'h1);
      end
      if (e == 5) begin
        chk("mid_exec_inst", 32'(inst1), 32'h2);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_w", 32'(w1), 32'h0);
    chk("mid_rst_c", 32'(c1), 32'h0);
    chk("mid_rst_z", 32'(z1), 32'h0);
    chk("mid_rst_busy", 32'(busy1), 32'h0);
    chk("mid_rst_done", 32'(done1), 32'h0);
    chk("mid_rst_inst", 32'(inst1), 32'h8);
    chk("mid_rst_addr", 32'(addr1), 32'h0);
    repeat (3) @(negedge clk);
    chk("mid_rst_stays_idle", 32'(busy1), 32'h0);
    chk("mid_rst_w_held", 32'(w1), 32'h0);

    // ---- start held high: program reruns after DONE->IDLE ----
    for (int j = 0; j < 16; j++) mem1[j] = 12'hF00;
    do_reset();
    start = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      if (e == 2) chk("hold_done1", 32'(done1), 32'h1);
      if (e == 3) begin
        chk("hold_idle_busy", 32'(busy1), 32'h0);
        chk("hold_idle_done", 32'(done1), 32'h0);
      end
      if (e == 4) chk("hold_rerun_busy", 32'(busy1), 32'h1);
      if (e == 6) chk("hold_done2", 32'(done1), 32'h1);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
